psc_frame_gen: RTL and testbench

//  Parametrised, handshaked serialiser for PSC link frames, one byte per beat.

---
 rtl/psc_frame_gen.sv | 203 ++++++++++++++++++++
 tb/tb_psc_frame_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/psc_frame_gen.sv
// psc_frame_gen: handshaked byte serialiser for PSC link frames (SOP, ADDR, CMD, RSV, payload, EOP).
// Define PSC_FRAME_CHECKSUM_EN to insert an XOR checksum beat between payload and EOP.
module psc_frame_gen #(
  parameter int         NUM_CH        = 4,
  parameter int         PAYLOAD_BYTES = 5,
  parameter int         EOP_COUNT     = 2,
  parameter logic [7:0] BASE_ADDR     = 8'h01,
  parameter logic [7:0] TRIG_CMD      = 8'h30,
  parameter logic [7:0] DATA_CMD      = 8'h00,
  parameter logic [7:0] SOP_CHAR      = 8'h3C,
  parameter logic [7:0] EOP_CHAR      = 8'hBC,
  localparam int        CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [CHW-1:0]             req_ch,
  input  logic                       req_trigger,
  input  logic [8*PAYLOAD_BYTES-1:0] req_payload,
  input  logic                       abort,
  output logic [7:0]                 tx_data,
  output logic                       tx_k,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_aborted
);

  localparam int MAX_BEATS = (PAYLOAD_BYTES > EOP_COUNT) ?
                             ((PAYLOAD_BYTES > 3) ? PAYLOAD_BYTES : 3) :
                             ((EOP_COUNT > 3) ? EOP_COUNT : 3);
  localparam int CW = $clog2(MAX_BEATS);

  localparam logic [CW-1:0] HDR_LAST = CW'(2);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_BYTES - 1);
  localparam logic [CW-1:0] EOP_LAST = CW'(EOP_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SOP,
    HDR,
    PAY,
`ifdef PSC_FRAME_CHECKSUM_EN
    CSUM,
`endif
    EOP
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [CHW-1:0]             ch_q;
  logic                       trig_q;
  logic [8*PAYLOAD_BYTES-1:0] pay_q;
  logic                       abort_q;
  logic                       fire, accept, abort_now, last_eop;
  logic [7:0]                 data_nxt;
  logic                       k_nxt, valid_nxt;

  assign fire      = tx_valid && tx_ready;
  assign accept    = (state == IDLE) && req_valid;
  assign abort_now = abort_q || abort;
  assign last_eop  = (state == EOP) && fire && (cnt == EOP_LAST);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef PSC_FRAME_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every header and payload byte already handed over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                csum_q <= 8'h00;
    else if (accept)                             csum_q <= 8'h00;
    else if (fire && (state == HDR || state == PAY)) csum_q <= csum_q ^ tx_data;
  end
`endif

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        state_nxt = SOP;
        cnt_nxt   = '0;
      end
      SOP: if (fire) begin
        state_nxt = abort_now ? EOP : HDR;
        cnt_nxt   = '0;
      end
      HDR: if (fire) begin
        if (abort_now || cnt == HDR_LAST) begin
          state_nxt = abort_now ? EOP : PAY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PAY: if (fire) begin
        if (abort_now) begin
          state_nxt = EOP;
          cnt_nxt   = '0;
        end else if (cnt == PAY_LAST) begin
`ifdef PSC_FRAME_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = EOP;
`endif
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef PSC_FRAME_CHECKSUM_EN
      CSUM: if (fire) begin
        state_nxt = EOP;
        cnt_nxt   = '0;
      end
`endif
      EOP: if (fire) begin
        if (cnt == EOP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Byte for the beat about to be presented; it is registered straight onto tx_*.
  always_comb begin
    data_nxt  = 8'h00;
    k_nxt     = 1'b0;
    valid_nxt = 1'b1;
    case (state_nxt)
      SOP: begin
        data_nxt = SOP_CHAR;
        k_nxt    = 1'b1;
      end
      HDR: begin
        if (cnt_nxt == '0)          data_nxt = BASE_ADDR + 8'(ch_q);
        else if (cnt_nxt == CW'(1)) data_nxt = trig_q ? TRIG_CMD : DATA_CMD;
        else                        data_nxt = 8'h00;
      end
      PAY:  data_nxt = pay_q[8*(PAYLOAD_BYTES-1-int'(cnt_nxt)) +: 8];
`ifdef PSC_FRAME_CHECKSUM_EN
      CSUM: data_nxt = csum_q ^ tx_data;
`endif
      EOP: begin
        data_nxt = EOP_CHAR;
        k_nxt    = 1'b1;
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      tx_data       <= 8'h00;
      tx_k          <= 1'b0;
      tx_valid      <= 1'b0;
      abort_q       <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      frame_done    <= last_eop;
      frame_aborted <= last_eop && abort_q;
      // Outputs only move on a handshake (or from IDLE), so stalled beats stay stable.
      if (state == IDLE || fire) begin
        tx_data  <= data_nxt;
        tx_k     <= k_nxt;
        tx_valid <= valid_nxt;
      end
      if (state == IDLE)                  abort_q <= 1'b0;
      else if (abort && state != EOP)     abort_q <= 1'b1;
    end
  end

  // NOTE: the request copy is reset as well so a frame can never carry stale pre-reset X data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q   <= '0;
      trig_q <= 1'b0;
      pay_q  <= '0;
    end else if (accept) begin
      ch_q   <= req_ch;
      trig_q <= req_trigger;
      pay_q  <= req_payload;
    end
  end

endmodule

// File: tb/tb_psc_frame_gen.sv
// Directed self-checking bench for psc_frame_gen with default parameters.
// Honours PSC_FRAME_CHECKSUM_EN by expecting the extra checksum beat.
module tb_psc_frame_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ch;
  logic        req_trigger;
  logic [39:0] req_payload;
  logic        abort;
  logic [7:0]  tx_data;
  logic        tx_k;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic        frame_aborted;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         abort_at  = -1;
  int         change_at = -1;

  always #5 clk = ~clk;

  psc_frame_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ch        (req_ch),
    .req_trigger   (req_trigger),
    .req_payload   (req_payload),
    .abort         (abort),
    .tx_data       (tx_data),
    .tx_k          (tx_k),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic k, input logic [7:0] d);
    exp_q.push_back({k, d});
  endtask

  // Called on a negedge with the frame's first beat visible; returns on the negedge after the last handshake.
  task automatic recv(input string tag, input bit toggle, input logic exp_ab);
    int         idx     = 0;
    int         cyc     = 0;
    int         n       = exp_q.size();
    bit         stalled = 1'b0;
    logic [8:0] held    = '0;
    while (idx < n && cyc < 200) begin
      if (stalled)
        check($sformatf("%s stall%0d", tag, idx), {tx_valid, tx_k, tx_data}, {1'b1, held});
      stalled = 1'b0;
      if (tx_valid && tx_ready) begin
        check($sformatf("%s beat%0d", tag, idx), {tx_k, tx_data}, exp_q[idx]);
        check($sformatf("%s done_low%0d", tag, idx), frame_done, 0);
        if (idx == abort_at) abort = 1'b1;
        if (idx == change_at) begin
          req_ch      = 2'd0;
          req_trigger = 1'b0;
          req_payload = 40'hFFEEDDCCBB;
        end
        idx++;
      end else if (tx_valid) begin
        stalled = 1'b1;
        held    = {tx_k, tx_data};
      end
      cyc++;
      @(negedge clk);
      abort    = 1'b0;
      tx_ready = toggle ? ~tx_ready : 1'b1;
    end
    check({tag, " beats_seen"}, idx, n);
    check({tag, " frame_done"}, frame_done, 1);
    check({tag, " frame_aborted"}, frame_aborted, exp_ab);
    check({tag, " idle_valid"}, tx_valid, 0);
    check({tag, " idle_ready"}, req_ready, 1);
    check({tag, " idle_busy"}, busy, 0);
    exp_q.delete();
    abort_at  = -1;
    change_at = -1;
    tx_ready  = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_ch      = 2'd0;
    req_trigger = 1'b0;
    req_payload = '0;
    abort       = 1'b0;
    tx_ready    = 1'b1;

    // Reset values
    #12;
    check("rst tx_data", tx_data, 0);
    check("rst tx_k", tx_k, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst frame_aborted", frame_aborted, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", req_ready, 1);

    // Trigger frame, ch0, zero payload, tx_ready held high
    req_valid   = 1'b1;
    req_ch      = 2'd0;
    req_trigger = 1'b1;
    req_payload = 40'h0;
    check("f1 pre-accept valid", tx_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("f1 sop latency", tx_valid, 1);
    push(1, 8'h3C); push(0, 8'h01); push(0, 8'h30); push(0, 8'h00);
    push(0, 8'h00); push(0, 8'h00); push(0, 8'h00); push(0, 8'h00); push(0, 8'h00);
`ifdef PSC_FRAME_CHECKSUM_EN
    push(0, 8'h31);
`endif
    push(1, 8'hBC); push(1, 8'hBC);
    recv("f1", 1'b0, 1'b0);
    @(negedge clk);
    check("f1 done pulse width", frame_done, 0);

    // Data frame, ch3, stalls on every other cycle
    req_valid   = 1'b1;
    req_ch      = 2'd3;
    req_trigger = 1'b0;
    req_payload = 40'h1122334455;
    @(negedge clk);
    req_valid = 1'b0;
    check("f2 sop latency", tx_valid, 1);
    push(1, 8'h3C); push(0, 8'h04); push(0, 8'h00); push(0, 8'h00);
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44); push(0, 8'h55);
`ifdef PSC_FRAME_CHECKSUM_EN
    push(0, 8'h15);
`endif
    push(1, 8'hBC); push(1, 8'hBC);
    recv("f2", 1'b1, 1'b0);
    @(negedge clk);

    // Abort while the 2nd payload byte is on the wire
    req_valid   = 1'b1;
    req_ch      = 2'd1;
    req_trigger = 1'b1;
    req_payload = 40'hA1B2C3D4E5;
    @(negedge clk);
    req_valid = 1'b0;
    push(1, 8'h3C); push(0, 8'h02); push(0, 8'h30); push(0, 8'h00);
    push(0, 8'hA1); push(0, 8'hB2);
    push(1, 8'hBC); push(1, 8'hBC);
    abort_at = 5;
    recv("abort", 1'b0, 1'b1);
    @(negedge clk);
    check("abort flag cleared", frame_aborted, 0);

    // Request held across the frame, fields changed mid-frame, then back-to-back
    req_valid   = 1'b1;
    req_ch      = 2'd2;
    req_trigger = 1'b1;
    req_payload = 40'h0102030405;
    @(negedge clk);
    check("b2b-a sop latency", tx_valid, 1);
    push(1, 8'h3C); push(0, 8'h03); push(0, 8'h30); push(0, 8'h00);
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h04); push(0, 8'h05);
`ifdef PSC_FRAME_CHECKSUM_EN
    push(0, 8'h32);
`endif
    push(1, 8'hBC); push(1, 8'hBC);
    change_at = 6;
    recv("b2b-a", 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b-b sop after idle", tx_valid, 1);
    push(1, 8'h3C); push(0, 8'h01); push(0, 8'h00); push(0, 8'h00);
    push(0, 8'hFF); push(0, 8'hEE); push(0, 8'hDD); push(0, 8'hCC); push(0, 8'hBB);
`ifdef PSC_FRAME_CHECKSUM_EN
    push(0, 8'hBA);
`endif
    push(1, 8'hBC); push(1, 8'hBC);
    recv("b2b-b", 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame
    req_valid   = 1'b1;
    req_ch      = 2'd1;
    req_trigger = 1'b0;
    req_payload = 40'h5A5A5A5A5A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy before rst", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid-rst tx_valid", tx_valid, 0);
    check("mid-rst tx_data", tx_data, 0);
    check("mid-rst tx_k", tx_k, 0);
    check("mid-rst busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("after mid-rst req_ready", req_ready, 1);
    check("after mid-rst tx_valid", tx_valid, 0);
    check("after mid-rst frame_done", frame_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
